// File: rtl/uart_pkg.sv
// ============================================================================
//  Module : uart_pkg
//  Brief  : Shared UART types and constants: arbiter state encoding,
//           frame delimiters and the default per-byte stall limit.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        XMIT = 2'd2,
        WAIT = 2'd3
    } arb_state_t;

    localparam logic [7:0] DELIM1 = 8'hAA;
    localparam logic [7:0] DELIM2 = 8'h55;

    // One byte time at 50 MHz is far shorter; this is a 20.8 ms stall limit.
    localparam int unsigned DEF_TIMEOUT_CYC = 1041666;

endpackage

`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_pick.sv
// ============================================================================
//  Module : rr_pick
//  Brief  : Combinational round-robin picker. Searches i_req from i_ptr
//           upward with wrap; returns a one-hot winner and its index.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter  int NUM_REQ = 2,
    localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IW-1:0]      o_idx,
    output logic               o_any
);

    int          w_cand;
    logic [IW-1:0] w_cand_idx;

    always_comb begin
        o_gnt      = '0;
        o_idx      = '0;
        o_any      = 1'b0;
        w_cand     = 0;
        w_cand_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = int'(i_ptr) + i;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            w_cand_idx = w_cand[IW-1:0];
            if (!o_any && i_req[w_cand_idx]) begin
                o_any             = 1'b1;
                o_gnt[w_cand_idx] = 1'b1;
                o_idx             = w_cand_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
//  Module : uart_tx_arbiter
//  Brief  : Frame-atomic round-robin arbiter sharing one UART_tx between
//           NUM_REQ byte-stream sources. Optional stall timeout under
//           `ARB_TIMEOUT_EN` (default build: no timeout, abort tied low).
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int          NUM_REQ     = 2,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_vld,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 trmt,
    output logic [7:0]           tx_data,
    input  logic                 tx_done,
    output logic                 abort
);

    localparam int            c_iw       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [c_iw-1:0] c_last_idx = c_iw'(NUM_REQ - 1);

    if (NUM_REQ < 1 || NUM_REQ > 8) begin : g_num_req_chk
        $error("NUM_REQ must be in 1..8");
    end
    if (TIMEOUT_CYC < 2) begin : g_timeout_chk
        $error("TIMEOUT_CYC must be at least 2");
    end

    arb_state_t        r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [c_iw-1:0]   r_gidx;
    logic [c_iw-1:0]   r_rr_ptr;
    logic              r_last;
    logic              r_trmt;
    logic [7:0]        r_tx_data;

    logic [NUM_REQ-1:0] w_pick_gnt;
    logic [c_iw-1:0]    w_pick_idx;
    logic               w_pick_any;
    logic               w_vld_g;
    logic [7:0]         w_data_g;
    logic               w_last_g;
    logic [c_iw-1:0]    w_next_ptr;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .i_req (req_vld),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    assign w_vld_g    = req_vld[r_gidx];
    assign w_data_g   = req_data[r_gidx*8 +: 8];
    assign w_last_g   = req_last[r_gidx];
    // The owner just served drops to lowest priority for the next frame.
    assign w_next_ptr = (r_gidx == c_last_idx) ? '0 : r_gidx + 1'b1;

`ifdef ARB_TIMEOUT_EN
    localparam int              c_cw     = $clog2(TIMEOUT_CYC);
    localparam logic [c_cw-1:0] c_to_max = c_cw'(TIMEOUT_CYC - 1);

    logic [c_cw-1:0] r_stall;
    logic            r_abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_gidx    <= '0;
            r_rr_ptr  <= '0;
            r_last    <= 1'b0;
            r_trmt    <= 1'b0;
            r_tx_data <= 8'h00;
            r_stall   <= '0;
            r_abort   <= 1'b0;
        end else begin
            r_trmt  <= 1'b0;
            r_abort <= 1'b0;
            case (r_state)
                IDLE: if (w_pick_any) begin
                    r_grant <= w_pick_gnt;
                    r_gidx  <= w_pick_idx;
                    r_stall <= '0;
                    r_state <= SEND;
                end
                SEND: if (w_vld_g) begin
                    r_tx_data <= w_data_g;
                    r_last    <= w_last_g;
                    r_trmt    <= 1'b1;
                    r_state   <= XMIT;
                end else if (r_stall == c_to_max) begin
                    r_abort  <= 1'b1;
                    r_grant  <= '0;
                    r_rr_ptr <= w_next_ptr;
                    r_state  <= IDLE;
                end else begin
                    r_stall <= r_stall + 1'b1;
                end
                XMIT: r_state <= WAIT;
                WAIT: if (tx_done) begin
                    if (r_last) begin
                        r_grant  <= '0;
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= IDLE;
                    end else begin
                        r_stall <= '0;
                        r_state <= SEND;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign abort = r_abort;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_gidx    <= '0;
            r_rr_ptr  <= '0;
            r_last    <= 1'b0;
            r_trmt    <= 1'b0;
            r_tx_data <= 8'h00;
        end else begin
            r_trmt <= 1'b0;
            case (r_state)
                IDLE: if (w_pick_any) begin
                    r_grant <= w_pick_gnt;
                    r_gidx  <= w_pick_idx;
                    r_state <= SEND;
                end
                SEND: if (w_vld_g) begin
                    r_tx_data <= w_data_g;
                    r_last    <= w_last_g;
                    r_trmt    <= 1'b1;
                    r_state   <= XMIT;
                end
                XMIT: r_state <= WAIT;
                WAIT: if (tx_done) begin
                    if (r_last) begin
                        r_grant  <= '0;
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= IDLE;
                    end else begin
                        r_state <= SEND;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign abort = 1'b0;
`endif

    // The ack is combinational so the source can advance on the same edge
    // that latches its byte into tx_data.
    always_comb begin
        req_ack = '0;
        if (r_state == SEND && w_vld_g) begin
            req_ack = r_grant;
        end
    end

    assign grant   = r_grant;
    assign busy    = (r_state != IDLE);
    assign trmt    = r_trmt;
    assign tx_data = r_tx_data;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
//  Module : tb_uart_tx_arbiter
//  Brief  : Directed self-checking bench for uart_tx_arbiter (NUM_REQ=2)
//           with a behavioural UART_tx done-flag model.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int BYTE_CYC = 6;
    localparam int BOUND    = 3000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_vld;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ack;
    logic [1:0]  grant;
    logic        busy;
    logic        trmt;
    logic [7:0]  tx_data;
    logic        tx_done;
    logic        abort;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ     (2),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_vld  (req_vld),
        .req_data (req_data),
        .req_last (req_last),
        .req_ack  (req_ack),
        .grant    (grant),
        .busy     (busy),
        .trmt     (trmt),
        .tx_data  (tx_data),
        .tx_done  (tx_done),
        .abort    (abort)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // UART_tx model: done flag stays high until trmt, then rises after BYTE_CYC.
    int u_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_done <= 1'b1;
            u_cnt   <= 0;
        end else if (trmt) begin
            tx_done <= 1'b0;
            u_cnt   <= BYTE_CYC;
        end else if (u_cnt > 0) begin
            u_cnt <= u_cnt - 1;
            if (u_cnt == 1) tx_done <= 1'b1;
        end
    end

    // Requester sources: entry = {last, byte}; pop on ack after the edge.
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [1:0] hold = 2'b00;
    logic [1:0] ack_s;

    initial begin
        req_vld  = '0;
        req_data = '0;
        req_last = '0;
        forever begin
            @(negedge clk);
            ack_s = req_ack;
            @(posedge clk);
            #1;
            if (ack_s[0] && q0.size() > 0) q0.delete(0);
            if (ack_s[1] && q1.size() > 0) q1.delete(0);
            req_vld[0]     = (q0.size() > 0) && !hold[0];
            req_data[7:0]  = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
            req_last[0]    = (q0.size() > 0) ? q0[0][8] : 1'b0;
            req_vld[1]     = (q1.size() > 0) && !hold[1];
            req_data[15:8] = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
            req_last[1]    = (q1.size() > 0) ? q1[0][8] : 1'b0;
        end
    end

    // Monitor: log {grant, tx_data} at every trmt, count acks/aborts/back-to-back trmt.
    logic [9:0] log_q[$];
    int  ack_n0 = 0, ack_n1 = 0, abort_n = 0, dbl_n = 0;
    logic prev_trmt = 1'b0;
    always @(negedge clk) begin
        if (trmt) log_q.push_back({grant, tx_data});
        if (req_ack[0]) ack_n0++;
        if (req_ack[1]) ack_n1++;
        if (abort) abort_n++;
        if (trmt && prev_trmt) dbl_n++;
        prev_trmt = trmt;
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_log(input int n, input string tag);
        int k = 0;
        while (log_q.size() < n && k < BOUND) begin step(); k++; end
        if (k >= BOUND) chk(tag, log_q.size(), n);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (!(q0.size() == 0 && q1.size() == 0 && !busy) && k < BOUND) begin step(); k++; end
        if (k >= BOUND) chk(tag, {31'd0, busy}, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [9:0] exp3 [12];
    int lb, b0, b1, n, gap;

    initial begin
        exp3 = '{10'h220, 10'h221, 10'h110, 10'h111, 10'h222, 10'h223,
                 10'h112, 10'h113, 10'h224, 10'h225, 10'h114, 10'h115};

        // Reset state
        step(3);
        chk("rst_grant", grant, 0);
        chk("rst_trmt", trmt, 0);
        chk("rst_txdata", tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_abort", abort, 0);
        chk("rst_ack", req_ack, 0);
        rst = 1'b0;
        step();

        // Reset mid-WAIT, then simultaneous requests favour requester 0
        q1.push_back({1'b0, 8'h90});
        q1.push_back({1'b1, 8'h91});
        wait_log(1, "t1_first_trmt");
        step(2);
        chk("t1_busy_midframe", busy, 1);
        chk("t1_grant_midframe", grant, 2'b10);
        rst = 1'b1;
        q0.delete();
        q1.delete();
        step();
        chk("t1_rst_grant", grant, 0);
        chk("t1_rst_trmt", trmt, 0);
        chk("t1_rst_txdata", tx_data, 0);
        chk("t1_rst_busy", busy, 0);
        step();
        rst = 1'b0;
        step();
        lb = log_q.size();
        q0.push_back({1'b1, 8'hA0});
        q1.push_back({1'b1, 8'hB0});
        wait_idle("t1_idle_timeout");
        chk("t1_nlog", log_q.size() - lb, 2);
        chk("t1_first_owner", log_q[lb], {2'b01, 8'hA0});
        chk("t1_second_owner", log_q[lb+1], {2'b10, 8'hB0});

        // Requester 0 four-byte frame
        lb = log_q.size(); b0 = ack_n0; b1 = ack_n1;
        q0.push_back({1'b0, DELIM1});
        q0.push_back({1'b0, DELIM2});
        q0.push_back({1'b0, 8'h01});
        q0.push_back({1'b1, 8'h23});
        wait_idle("t2_idle_timeout");
        chk("t2_ntrmt", log_q.size() - lb, 4);
        chk("t2_b0", log_q[lb],   {2'b01, 8'hAA});
        chk("t2_b1", log_q[lb+1], {2'b01, 8'h55});
        chk("t2_b2", log_q[lb+2], {2'b01, 8'h01});
        chk("t2_b3", log_q[lb+3], {2'b01, 8'h23});
        chk("t2_ack0", ack_n0 - b0, 4);
        chk("t2_ack1", ack_n1 - b1, 0);
        chk("t2_grant_released", grant, 0);

        // Six back-to-back two-byte frames alternate ownership (rr_ptr now 1)
        lb = log_q.size();
        for (int i = 0; i < 3; i++) begin
            q0.push_back({1'b0, 8'h10 + 8'(2*i)});
            q0.push_back({1'b1, 8'h11 + 8'(2*i)});
            q1.push_back({1'b0, 8'h20 + 8'(2*i)});
            q1.push_back({1'b1, 8'h21 + 8'(2*i)});
        end
        wait_idle("t3_idle_timeout");
        chk("t3_ntrmt", log_q.size() - lb, 12);
        for (int i = 0; i < 12; i++) chk($sformatf("t3_byte%0d", i), log_q[lb+i], exp3[i]);

        // Late request from requester 1 waits for the whole frame of requester 0
        lb = log_q.size();
        q0.push_back({1'b0, 8'h30});
        q0.push_back({1'b0, 8'h31});
        q0.push_back({1'b1, 8'h32});
        wait_log(lb + 1, "t4_first_trmt");
        q1.push_back({1'b1, 8'h40});
        wait_log(lb + 3, "t4_last_trmt");
        n = 0;
        while (grant == 2'b01 && n < BOUND) begin step(); n++; end
        gap = 0;
        while (grant == 2'b00 && gap < 20) begin step(); gap++; end
        chk("t4_idle_gap", gap, 1);
        chk("t4_new_grant", grant, 2'b10);
        wait_idle("t4_idle_timeout");
        chk("t4_b0", log_q[lb],   {2'b01, 8'h30});
        chk("t4_b1", log_q[lb+1], {2'b01, 8'h31});
        chk("t4_b2", log_q[lb+2], {2'b01, 8'h32});
        chk("t4_b3", log_q[lb+3], {2'b10, 8'h40});

        // Owner stalls in SEND while tx_done is still high: no spurious trmt
        lb = log_q.size();
        q0.push_back({1'b0, 8'h60});
        q0.push_back({1'b1, 8'h61});
        wait_log(lb + 1, "t5_first_trmt");
        hold[0] = 1'b1;
        step(10);
        chk("t5_no_trmt_stall", log_q.size() - lb, 1);
        chk("t5_busy_stall", busy, 1);
        chk("t5_grant_stall", grant, 2'b01);
        chk("t5_no_ack_stall", req_ack, 0);
        hold[0] = 1'b0;
        wait_idle("t5_idle_timeout");
        chk("t5_ntrmt", log_q.size() - lb, 2);
        chk("t5_b1", log_q[lb+1], {2'b01, 8'h61});

`ifdef ARB_TIMEOUT_EN
        // Stalled owner is force-released after 16 SEND cycles
        lb = log_q.size();
        q0.push_back({1'b0, 8'h70});
        q0.push_back({1'b0, 8'h71});
        q0.push_back({1'b1, 8'h72});
        wait_log(lb + 1, "t6_first_trmt");
        hold[0] = 1'b1;
        q1.push_back({1'b1, 8'h80});
        n = 0;
        while (tx_done && n < 50) begin step(); n++; end
        n = 0;
        while (!tx_done && n < 50) begin step(); n++; end
        n = 0;
        while (!abort && n < 100) begin step(); n++; end
        chk("t6_abort_latency", n, 17);
        chk("t6_grant_at_abort", grant, 0);
        chk("t6_busy_at_abort", busy, 0);
        step();
        chk("t6_abort_width", abort, 0);
        chk("t6_next_grant", grant, 2'b10);
        q0.delete();
        hold[0] = 1'b0;
        wait_idle("t6_idle_timeout");
        chk("t6_ntrmt", log_q.size() - lb, 2);
        chk("t6_b1", log_q[lb+1], {2'b10, 8'h80});
        chk("t6_abort_count", abort_n, 1);
`else
        chk("abort_never", abort_n, 0);
`endif

        chk("no_back_to_back_trmt", dbl_n, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
